// File: rtl/dram_frame_write_scheduler.sv
// Drains the camera gearbox FIFO into a ring of DRAM frame buffers, one 512-bit beat per issue.
// Each issue is followed by a guard window before the next one. Completed frames are reported with their slot index.
module dram_frame_write_scheduler #(
    parameter int                         DRAM_ADDR_WIDTH = 39,
    parameter logic [DRAM_ADDR_WIDTH-1:0] DRAM_ADDR_BASE  = 39'h400000000,
    parameter int                         DRAM_DATA_WIDTH = 512,
    parameter int                         NUM_SLOTS       = 4,
    parameter logic [DRAM_ADDR_WIDTH-1:0] SLOT_STRIDE     = 39'h001000000,
    parameter int                         GUARD_CYCLES    = 16
) (
    input  logic                         m_axi_aclk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [23:0]                  frame_beats,
    input  logic                         fifo_empty,
    input  logic                         dram_write_busy,
    output logic                         dram_write_en,
    output logic [DRAM_ADDR_WIDTH-1:0]   dram_write_addr,
    output logic [7:0]                   dram_write_len,
    output logic                         frame_done,
    output logic [$clog2(NUM_SLOTS)-1:0] frame_slot,
    output logic [15:0]                  frame_count,
    output logic                         active,
    output logic [1:0]                   dbg_state
);

    localparam int SLOT_W     = $clog2(NUM_SLOTS);
    localparam int BEAT_BYTES = DRAM_DATA_WIDTH / 8;
    localparam int GCNT_W     = $clog2(GUARD_CYCLES) + 1;
    localparam logic [GCNT_W-1:0] GUARD_LAST = GCNT_W'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GUARD = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                       r_state;
    logic [SLOT_W-1:0]            r_slot;
    logic [23:0]                  r_beat_idx;
    logic [23:0]                  r_beats_left;
    logic [GCNT_W-1:0]            r_guard_cnt;
    logic                         r_write_en;
    logic [DRAM_ADDR_WIDTH-1:0]   r_write_addr;
    logic                         r_frame_done;
    logic [SLOT_W-1:0]            r_frame_slot;
    logic [15:0]                  r_frame_count;
    logic                         r_active;

    logic [DRAM_ADDR_WIDTH-1:0]   w_slot_off;
    logic [DRAM_ADDR_WIDTH-1:0]   w_beat_off;
    logic [DRAM_ADDR_WIDTH-1:0]   w_cur_addr;
    logic                         w_fire;
    logic                         w_guard_ok;

    // Address arithmetic wraps naturally at the address width.
    assign w_slot_off = DRAM_ADDR_WIDTH'(r_slot) * SLOT_STRIDE;
    assign w_beat_off = DRAM_ADDR_WIDTH'(r_beat_idx) * DRAM_ADDR_WIDTH'(BEAT_BYTES);
    assign w_cur_addr = DRAM_ADDR_BASE + w_slot_off + w_beat_off;

    // Handshake: a beat is issued only in a cycle where the FIFO has data and the engine is
    // not busy; dram_write_en is then a single-cycle strobe that doubles as the FIFO read enable.
    assign w_fire     = !fifo_empty && !dram_write_busy;
    assign w_guard_ok = (r_guard_cnt >= GUARD_LAST) && !dram_write_busy;

    always_ff @(posedge m_axi_aclk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_slot        <= '0;
            r_beat_idx    <= '0;
            r_beats_left  <= '0;
            r_guard_cnt   <= '0;
            r_write_en    <= 1'b0;
            r_write_addr  <= DRAM_ADDR_BASE;
            r_frame_done  <= 1'b0;
            r_frame_slot  <= '0;
            r_frame_count <= '0;
            r_active      <= 1'b0;
        end else begin
            r_write_en   <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable && !fifo_empty && (frame_beats != 24'd0)) begin
                        r_beats_left <= frame_beats;
                        r_beat_idx   <= '0;
                        r_state      <= S_ISSUE;
                        r_active     <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (w_fire) begin
                        r_write_en   <= 1'b1;
                        r_write_addr <= w_cur_addr;
                        r_guard_cnt  <= GCNT_W'(1);
                        r_state      <= S_GUARD;
                    end
                end
                S_GUARD: begin
                    if (w_guard_ok) begin
                        r_beats_left <= r_beats_left - 24'd1;
                        r_beat_idx   <= r_beat_idx + 24'd1;
                        if (r_beats_left == 24'd1) begin
                            r_state       <= S_DONE;
                            r_frame_done  <= 1'b1;
                            r_frame_slot  <= r_slot;
                            r_frame_count <= r_frame_count + 16'd1;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end else if (r_guard_cnt < GUARD_LAST) begin
                        r_guard_cnt <= r_guard_cnt + GCNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (r_slot == SLOT_W'(NUM_SLOTS - 1)) begin
                        r_slot <= '0;
                    end else begin
                        r_slot <= r_slot + SLOT_W'(1);
                    end
                    r_state  <= S_IDLE;
                    r_active <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign dram_write_en   = r_write_en;
    assign dram_write_addr = r_write_addr;
    assign dram_write_len  = 8'h00;
    assign frame_done      = r_frame_done;
    assign frame_slot      = r_frame_slot;
    assign frame_count     = r_frame_count;
    assign active          = r_active;
    assign dbg_state       = r_state;

endmodule

// File: tb/tb_dram_frame_write_scheduler.sv
// Self-checking bench for dram_frame_write_scheduler: directed frame table, corner-case
// sequences, and randomized busy/empty traffic against a transaction-level ring model.
module tb_dram_frame_write_scheduler;

    localparam int          AW     = 39;
    localparam logic [38:0] BASE   = 39'h400000000;
    localparam logic [38:0] STRIDE = 39'h001000000;
    localparam int          GUARD  = 16;
    localparam int          NSLOT  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [23:0] frame_beats;
    logic        fifo_empty;
    logic        busy;

    logic          dram_write_en;
    logic [AW-1:0] dram_write_addr;
    logic [7:0]    dram_write_len;
    logic          frame_done;
    logic [1:0]    frame_slot;
    logic [15:0]   frame_count;
    logic          active;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    dram_frame_write_scheduler dut (
        .m_axi_aclk      (clk),
        .reset           (reset),
        .enable          (enable),
        .frame_beats     (frame_beats),
        .fifo_empty      (fifo_empty),
        .dram_write_busy (busy),
        .dram_write_en   (dram_write_en),
        .dram_write_addr (dram_write_addr),
        .dram_write_len  (dram_write_len),
        .frame_done      (frame_done),
        .frame_slot      (frame_slot),
        .frame_count     (frame_count),
        .active          (active),
        .dbg_state       (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_strobe = -1000;

    logic [AW-1:0] obs_addr_q[$];
    int            obs_cyc_q[$];
    logic [1:0]    obs_slot_q[$];
    logic [15:0]   obs_cnt_q[$];

    logic edge_fifo_empty;
    logic edge_busy;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Inputs as seen by the DUT at each active edge.
    always @(posedge clk) begin
        edge_fifo_empty <= fifo_empty;
        edge_busy       <= busy;
    end

    // Monitor: records strobes and frame completions, and checks the per-issue rules.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            last_strobe = -1000;
        end else begin
            if (dram_write_en) begin
                chk("fire_fifo_nonempty", 64'(edge_fifo_empty), 64'(0));
                chk("fire_busy_low", 64'(edge_busy), 64'(0));
                chk("strobe_spacing_ge_guard", 64'((cyc - last_strobe) >= GUARD), 64'(1));
                chk("write_len", 64'(dram_write_len), 64'(0));
                obs_addr_q.push_back(dram_write_addr);
                obs_cyc_q.push_back(cyc);
                last_strobe = cyc;
            end
            if (frame_done) begin
                obs_slot_q.push_back(frame_slot);
                obs_cnt_q.push_back(frame_count);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_addr_q.delete();
        obs_cyc_q.delete();
        obs_slot_q.delete();
        obs_cnt_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        clear_obs();
        reset = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget, input string nm);
        int k = 0;
        while (obs_addr_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(nm, 64'(obs_addr_q.size() >= n), 64'(1));
    endtask

    task automatic wait_done(input int n, input int budget, input string nm);
        int k = 0;
        while (obs_slot_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(nm, 64'(obs_slot_q.size() >= n), 64'(1));
    endtask

    typedef struct {
        int          beats;
        logic [1:0]  slot;
        logic [15:0] count;
        logic [38:0] base;
    } frame_vec_t;

    frame_vec_t  tbl[6];
    int          n_rand;
    int          m_frame;
    int          m_beat;
    logic [38:0] r_addr;
    logic [38:0] e_addr;
    logic [1:0]  r_slot;
    logic [15:0] r_cnt;

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        frame_beats = 24'd0;
        fifo_empty = 1'b1;
        busy = 1'b0;

        tbl[0] = '{3, 2'd0, 16'd1, BASE};
        tbl[1] = '{2, 2'd1, 16'd2, BASE + STRIDE};
        tbl[2] = '{2, 2'd2, 16'd3, BASE + 39'h002000000};
        tbl[3] = '{2, 2'd3, 16'd4, BASE + 39'h003000000};
        tbl[4] = '{2, 2'd0, 16'd5, BASE};
        tbl[5] = '{1, 2'd1, 16'd6, BASE + STRIDE};

        // Reset state
        repeat (2) tick();
        chk("rst_write_en", 64'(dram_write_en), 64'(0));
        chk("rst_write_addr", 64'(dram_write_addr), 64'(BASE));
        chk("rst_write_len", 64'(dram_write_len), 64'(0));
        chk("rst_frame_done", 64'(frame_done), 64'(0));
        chk("rst_frame_slot", 64'(frame_slot), 64'(0));
        chk("rst_frame_count", 64'(frame_count), 64'(0));
        chk("rst_active", 64'(active), 64'(0));
        chk("rst_state_idle", 64'(dbg_state), 64'(0));

        // Table of back-to-back frames
        do_reset();
        fifo_empty = 1'b0;
        busy = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            frame_beats = 24'(tbl[i].beats);
            wait_done(1, 200, "tbl_done_seen");
            if (i == 5) enable = 1'b0;
            chk("tbl_beats", 64'(obs_addr_q.size()), 64'(tbl[i].beats));
            for (int j = 0; j < obs_addr_q.size(); j++) begin
                chk("tbl_addr", 64'(obs_addr_q[j]), 64'(tbl[i].base + 39'(j * 64)));
                if (j > 0) chk("tbl_spacing", 64'(obs_cyc_q[j] - obs_cyc_q[j-1]), 64'(GUARD));
            end
            if (obs_slot_q.size() > 0) begin
                chk("tbl_done_pulses", 64'(obs_slot_q.size()), 64'(1));
                chk("tbl_slot", 64'(obs_slot_q[0]), 64'(tbl[i].slot));
                chk("tbl_count", 64'(obs_cnt_q[0]), 64'(tbl[i].count));
            end
            clear_obs();
        end

        // Busy held high after the first strobe
        do_reset();
        frame_beats = 24'd2;
        enable = 1'b1;
        wait_strobes(1, 50, "busy_first_strobe");
        busy = 1'b1;
        enable = 1'b0;
        repeat (40) tick();
        chk("busy_no_strobe", 64'(obs_addr_q.size()), 64'(1));
        chk("busy_active", 64'(active), 64'(1));
        busy = 1'b0;
        wait_strobes(2, 60, "busy_second_strobe");
        if (obs_addr_q.size() >= 2) begin
            chk("busy_second_addr", 64'(obs_addr_q[1]), 64'(BASE + 39'h40));
            chk("busy_gap", 64'((obs_cyc_q[1] - obs_cyc_q[0]) >= 41), 64'(1));
        end
        wait_done(1, 60, "busy_done");
        repeat (20) tick();
        chk("busy_no_dup", 64'(obs_addr_q.size()), 64'(2));

        // FIFO empty stall mid-frame, enable dropped during beat 2 of 4
        do_reset();
        frame_beats = 24'd4;
        enable = 1'b1;
        wait_strobes(1, 50, "empty_first_strobe");
        fifo_empty = 1'b1;
        repeat (100) tick();
        chk("empty_no_strobe", 64'(obs_addr_q.size()), 64'(1));
        chk("empty_active", 64'(active), 64'(1));
        fifo_empty = 1'b0;
        wait_strobes(2, 60, "empty_resume");
        enable = 1'b0;
        wait_done(1, 200, "empty_done");
        chk("empty_beats", 64'(obs_addr_q.size()), 64'(4));
        for (int j = 0; j < obs_addr_q.size(); j++)
            chk("empty_addr", 64'(obs_addr_q[j]), 64'(BASE + 39'(j * 64)));
        repeat (40) tick();
        chk("disable_no_new_frame", 64'(obs_addr_q.size()), 64'(4));
        chk("disable_idle", 64'(active), 64'(0));
        chk("disable_count", 64'(frame_count), 64'(1));

        // Zero-beat frames never start
        do_reset();
        frame_beats = 24'd0;
        enable = 1'b1;
        repeat (50) tick();
        chk("zero_no_strobe", 64'(obs_addr_q.size()), 64'(0));
        chk("zero_inactive", 64'(active), 64'(0));
        chk("zero_state_idle", 64'(dbg_state), 64'(0));
        enable = 1'b0;

        // Asynchronous reset during the guard window of beat 2
        do_reset();
        frame_beats = 24'd4;
        enable = 1'b1;
        wait_strobes(2, 60, "rstg_second_strobe");
        repeat (3) tick();
        chk("rstg_active_before", 64'(active), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("rstg_write_en", 64'(dram_write_en), 64'(0));
        chk("rstg_write_addr", 64'(dram_write_addr), 64'(BASE));
        chk("rstg_frame_done", 64'(frame_done), 64'(0));
        chk("rstg_frame_count", 64'(frame_count), 64'(0));
        chk("rstg_active", 64'(active), 64'(0));
        frame_beats = 24'd1;
        repeat (3) tick();
        clear_obs();
        reset = 1'b0;
        wait_strobes(1, 50, "rstg_restart_strobe");
        if (obs_addr_q.size() > 0) chk("rstg_restart_addr", 64'(obs_addr_q[0]), 64'(BASE));
        wait_done(1, 60, "rstg_done");
        enable = 1'b0;
        if (obs_slot_q.size() > 0) begin
            chk("rstg_slot", 64'(obs_slot_q[0]), 64'(0));
            chk("rstg_count", 64'(obs_cnt_q[0]), 64'(1));
        end

        // Randomized busy/empty traffic against the ring model
        for (int ph = 0; ph < 2; ph++) begin
            do_reset();
            n_rand = $urandom_range(1, 4);
            frame_beats = 24'(n_rand);
            enable = 1'b1;
            m_frame = 0;
            m_beat = 0;
            for (int c = 0; c < 2500; c++) begin
                busy = ($urandom_range(0, 99) < 30);
                fifo_empty = ($urandom_range(0, 99) < 15);
                tick();
                while (obs_addr_q.size() > 0) begin
                    r_addr = obs_addr_q.pop_front();
                    void'(obs_cyc_q.pop_front());
                    e_addr = BASE + 39'(m_frame % NSLOT) * STRIDE + 39'(m_beat * 64);
                    chk("rand_beat_in_frame", 64'(m_beat < n_rand), 64'(1));
                    chk("rand_addr", 64'(r_addr), 64'(e_addr));
                    m_beat++;
                end
                while (obs_slot_q.size() > 0) begin
                    r_slot = obs_slot_q.pop_front();
                    r_cnt = obs_cnt_q.pop_front();
                    chk("rand_frame_beats", 64'(m_beat), 64'(n_rand));
                    chk("rand_slot", 64'(r_slot), 64'(m_frame % NSLOT));
                    chk("rand_count", 64'(r_cnt), 64'(16'(m_frame + 1)));
                    m_frame++;
                    m_beat = 0;
                end
            end
            enable = 1'b0;
            busy = 1'b0;
            fifo_empty = 1'b0;
            chk("rand_progress", 64'(m_frame >= 5), 64'(1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
